// File: rtl/uart_bridge_pkg.sv
// uart_bridge_pkg
//   Shared definitions for the UART register bridge: frame command bytes,
//   response bytes and the bridge FSM state encoding.
package uart_bridge_pkg;

   // Command bytes sent by the host, and the response bytes sent back.
   localparam logic [7:0] CMD_WR  = 8'h57;  // 'W'
   localparam logic [7:0] CMD_RD  = 8'h52;  // 'R'
   localparam logic [7:0] RSP_ACK = 8'h06;
   localparam logic [7:0] RSP_NAK = 8'h15;

   typedef enum logic [3:0] {
      IDLE,
      CMD_LAT,
      ADDR_WAIT,
      ADDR_LAT,
      DATA_WAIT,
      DATA_LAT,
      EXEC_WR,
      EXEC_RD,
      RD_LAT,
      SEND
   } state_t;

endpackage

// File: rtl/uart_reg_bridge_if.sv
// uart_reg_bridge_if
//   Bundles the UART FIFO user-side handshake and the register bus seen by
//   the bridge.
//   master : the bridge (pops RX, pushes TX, drives register strobes)
//   slave  : the FIFOs plus the register file
//   Signals: rd_data/rx_empty/rd_uart (RX FIFO), wr_data/wr_uart/tx_full
//   (TX FIFO), reg_addr/reg_wdata/reg_we/reg_re/reg_rdata (register bus),
//   frame_err (timeout abort pulse).
interface uart_reg_bridge_if #(
   parameter int DATA_BITS = 8
);
   logic [DATA_BITS-1:0] rd_data;
   logic                 rx_empty;
   logic                 rd_uart;
   logic [DATA_BITS-1:0] wr_data;
   logic                 wr_uart;
   logic                 tx_full;
   logic [DATA_BITS-1:0] reg_addr;
   logic [DATA_BITS-1:0] reg_wdata;
   logic                 reg_we;
   logic                 reg_re;
   logic [DATA_BITS-1:0] reg_rdata;
   logic                 frame_err;

   modport master (
      input  rd_data, rx_empty, tx_full, reg_rdata,
      output rd_uart, wr_data, wr_uart, reg_addr, reg_wdata, reg_we, reg_re,
             frame_err
   );

   modport slave (
      output rd_data, rx_empty, tx_full, reg_rdata,
      input  rd_uart, wr_data, wr_uart, reg_addr, reg_wdata, reg_we, reg_re,
             frame_err
   );
endinterface

// File: rtl/uart_bridge_timeout.sv
// uart_bridge_timeout
//   Saturating cycle counter used to detect a starved frame.
//   clk, reset_n : clock, async active-low reset
//   clr          : reload the count with zero (has priority over en)
//   en           : advance the count by one, stopping at LIMIT
//   expired      : count has reached LIMIT
module uart_bridge_timeout
   import uart_bridge_pkg::*;
#(
   parameter int LIMIT = 999999
) (
   input  logic clk,
   input  logic reset_n,
   input  logic clr,
   input  logic en,
   output logic expired
);

   localparam int W = (LIMIT < 1) ? 1 : $clog2(LIMIT + 1);
   localparam logic [W-1:0] LIM = W'(LIMIT);

   logic [W-1:0] cnt;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         cnt <= '0;
      end else if (clr) begin
         cnt <= '0;
      end else if (en && (cnt != LIM)) begin
         cnt <= cnt + 1'b1;
      end
   end

   assign expired = (cnt == LIM);

endmodule

// File: rtl/uart_reg_bridge.sv
// uart_reg_bridge
//   Command engine on the user side of a UART FIFO pair. Parses fixed-length
//   frames from the RX FIFO and turns them into single-cycle register reads
//   and writes, returning one response byte per frame to the TX FIFO.
//     W(0x57) ADDR DATA -> write, response ACK (0x06)
//     R(0x52) ADDR      -> read,  response is the read data byte
//     anything else     -> response NAK (0x15), only that byte consumed
//   Ports:
//     clk, reset_n : clock, async active-low reset
//     bus          : master side of uart_reg_bridge_if (FIFO handshakes,
//                    register bus, frame_err)
module uart_reg_bridge
   import uart_bridge_pkg::*;
#(
   parameter int DATA_BITS      = 8,
   parameter int TIMEOUT_CYCLES = 1000000
) (
   input  logic              clk,
   input  logic              reset_n,
   uart_reg_bridge_if.master bus
);

   localparam logic [DATA_BITS-1:0] C_WR  = DATA_BITS'(CMD_WR);
   localparam logic [DATA_BITS-1:0] C_RD  = DATA_BITS'(CMD_RD);
   localparam logic [DATA_BITS-1:0] R_ACK = DATA_BITS'(RSP_ACK);
   localparam logic [DATA_BITS-1:0] R_NAK = DATA_BITS'(RSP_NAK);

   state_t               state;
   logic [DATA_BITS-1:0] cmd_q;
   logic [DATA_BITS-1:0] addr_q;
   logic [DATA_BITS-1:0] wdata_q;
   logic [DATA_BITS-1:0] resp_q;
   logic                 we_q;
   logic                 re_q;
   // Low for the first cycle after reset so that nothing is popped while
   // reset is asserted, even though IDLE is a fetch state.
   logic                 active;

   logic in_wait;
   logic fetch_st;
   logic pop;
   logic expired;
   logic abort;

   assign in_wait  = (state == ADDR_WAIT) || (state == DATA_WAIT);
   assign fetch_st = in_wait || (state == IDLE);

   // The FIFO handshakes depend on the same-cycle flags: a pop is issued in
   // the wait state itself so rd_data is ready in the following *_LAT state,
   // and a push goes out in the first SEND cycle the TX FIFO has room.
   assign pop   = active && fetch_st && !bus.rx_empty;
   // A byte arriving on the expiry cycle is fetched instead of aborting.
   assign abort = in_wait && bus.rx_empty && expired;

   // Counter only runs while starved mid-frame; being cleared in every
   // other state makes it start from zero on entry to a wait state.
   uart_bridge_timeout #(
      .LIMIT (TIMEOUT_CYCLES - 1)
   ) u_timeout (
      .clk     (clk),
      .reset_n (reset_n),
      .clr     (!in_wait || !bus.rx_empty),
      .en      (in_wait && bus.rx_empty),
      .expired (expired)
   );

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state   <= IDLE;
         cmd_q   <= '0;
         addr_q  <= '0;
         wdata_q <= '0;
         resp_q  <= '0;
         we_q    <= 1'b0;
         re_q    <= 1'b0;
         active  <= 1'b0;
      end else begin
         active <= 1'b1;
         we_q   <= 1'b0;
         re_q   <= 1'b0;
         case (state)
            IDLE: begin
               if (pop) state <= CMD_LAT;
            end
            CMD_LAT: begin
               cmd_q <= bus.rd_data;
               if ((bus.rd_data == C_WR) || (bus.rd_data == C_RD)) begin
                  state <= ADDR_WAIT;
               end else begin
                  resp_q <= R_NAK;
                  state  <= SEND;
               end
            end
            ADDR_WAIT: begin
               if (pop)        state <= ADDR_LAT;
               else if (abort) state <= IDLE;
            end
            ADDR_LAT: begin
               addr_q <= bus.rd_data;
               if (cmd_q == C_WR) begin
                  state <= DATA_WAIT;
               end else begin
                  re_q  <= 1'b1;       // strobe lands in EXEC_RD
                  state <= EXEC_RD;
               end
            end
            DATA_WAIT: begin
               if (pop)        state <= DATA_LAT;
               else if (abort) state <= IDLE;
            end
            DATA_LAT: begin
               wdata_q <= bus.rd_data;
               we_q    <= 1'b1;        // strobe lands in EXEC_WR
               state   <= EXEC_WR;
            end
            EXEC_WR: begin
               resp_q <= R_ACK;
               state  <= SEND;
            end
            EXEC_RD: begin
               state <= RD_LAT;
            end
            RD_LAT: begin
               resp_q <= bus.reg_rdata;
               state  <= SEND;
            end
            SEND: begin
               if (!bus.tx_full) state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign bus.rd_uart   = pop;
   assign bus.wr_uart   = (state == SEND) && !bus.tx_full;
   assign bus.wr_data   = resp_q;
   assign bus.reg_addr  = addr_q;
   assign bus.reg_wdata = wdata_q;
   assign bus.reg_we    = we_q;
   assign bus.reg_re    = re_q;
   assign bus.frame_err = abort;

endmodule
